i2c_cmd_arbiter: RTL
====================

I2C_CMD_ARBITER -- requirements
Module: i2c_cmd_arbiter

Interface
REQ-001 The block SHALL use one clock `clk` and a synchronous, active-low reset `rst`; all state changes SHALL occur on the rising edge of `clk`.
REQ-002 Parameter TIMEOUT_CYC, default 1023: maximum WAIT cycles before abort; range 1..1023.
REQ-003 Parameter MAX_RETRY, default 2: re-issues allowed after NACK; range 0..3.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  synchronous reset, active-low.
REQ-006 req0_valid / req1_valid  input  1  requester holds its command.
REQ-007 req0_ready / req1_ready  output  1  command accepted this cycle.
REQ-008 req0_rw / req1_rw  input  1  1 = read, 0 = write.
REQ-009 req0_dev / req1_dev  input  7  device address.
REQ-010 req0_reg / req1_reg  input  8  register address.
REQ-011 req0_wdata / req1_wdata  input  8  write data.
REQ-012 rsp0_valid / rsp1_valid  output  1  one-cycle completion pulse to the owning requester.
REQ-013 rsp_rdata  output  8  read data, valid with rspN_valid.
REQ-014 rsp_err  output  2  00 ok, 01 NACK after retries, 10 timeout, valid with rspN_valid.
REQ-015 m_start  output  1  one-cycle pulse that launches a master transaction.
REQ-016 m_abort  output  1  one-cycle pulse that forces the master to idle.
REQ-017 m_rw, m_dev, m_reg, m_wdata  output  1/7/8/8  latched command, held stable from ISSUE until the block returns to IDLE.
REQ-018 m_done  input  1  one-cycle transaction-complete pulse from the master.
REQ-019 m_nack  input  1  NACK flag, sampled only when m_done = 1.
REQ-020 m_rdata  input  8  read byte, sampled only when m_done = 1.
REQ-021 busy  output  1  high in every state except IDLE.

Function
REQ-022 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-023 In IDLE, reqN_ready SHALL be driven combinationally and only to the granted requester; a transfer occurs when valid and ready are both 1.
REQ-024 Arbitration: when only one request is valid, it is granted; when both are valid, the requester other than last_grant is granted (round-robin).
REQ-025 On a transfer, the block SHALL latch rw, dev, reg and wdata, clear retry_cnt and go to ISSUE on the next cycle.
REQ-026 ISSUE SHALL last exactly 1 cycle: m_start = 1, timer cleared, next state WAIT.
REQ-027 In WAIT, the 10-bit timer SHALL increment once per cycle while m_done = 0.
REQ-028 WAIT, m_done = 1 and m_nack = 0: go to RESP with err = 00; rdata = m_rdata when rw = 1, else 0x00.
REQ-029 WAIT, m_done = 1, m_nack = 1 and retry_cnt < MAX_RETRY: increment retry_cnt and go to ISSUE.
REQ-030 WAIT, m_done = 1, m_nack = 1 and retry_cnt = MAX_RETRY: go to RESP with err = 01 and rdata = 0x00.
REQ-031 WAIT, timer = TIMEOUT_CYC and m_done = 0: pulse m_abort for 1 cycle and go to RESP with err = 10 and rdata = 0x00.
REQ-032 If m_done = 1 in the same cycle the timer reaches TIMEOUT_CYC, m_done SHALL win and m_abort SHALL NOT pulse.
REQ-033 RESP SHALL last exactly 1 cycle: rspN_valid = 1 for the owner only, rsp_rdata and rsp_err valid, last_grant updated to the owner, next state IDLE.
REQ-034 No new request SHALL be accepted in the RESP cycle; the earliest next acceptance is the cycle after RESP.
REQ-035 m_done outside WAIT SHALL be ignored.
REQ-036 Latency: transfer at cycle T -> m_start at T+1; m_done at cycle D -> rspN_valid at D+1.
REQ-037 rsp_rdata and rsp_err SHALL hold their values until the next RESP.

Reset
REQ-038 While rst = 0 (sampled at a clock edge), the block SHALL enter IDLE and set last_grant = 1 (so requester 0 wins the first tie), timer = 0, retry_cnt = 0 and all latched fields to 0.
REQ-039 During reset, all outputs SHALL be 0: ready, rsp, m_start, m_abort, m_* buses, rsp_rdata, rsp_err and busy.
REQ-040 Reset asserted mid-transaction SHALL drop the transaction with no rsp pulse and no m_abort pulse.

Verification
REQ-041 Both requests valid out of reset, write dev 0x50 reg 0x10 data 0xA5 -> req0 is granted first; m_start the next cycle with m_dev = 0x50; m_done with m_nack = 0 -> rsp0_valid with err = 00 and rdata = 0x00; req1 is granted after that.
REQ-042 req1 read, m_done with m_rdata = 0x3C -> rsp1_valid one cycle after m_done, rsp_rdata = 0x3C, err = 00.
REQ-043 MAX_RETRY = 2, m_nack = 1 on three consecutive m_done pulses -> exactly 3 m_start pulses, then err = 01.
REQ-044 TIMEOUT_CYC = 20 with no m_done -> m_abort 20 cycles into WAIT, then rsp pulse with err = 10; m_done coinciding with timeout -> err = 00 and no m_abort.
REQ-045 rst driven low during WAIT -> the next cycle shows busy = 0 and all outputs 0; no rsp or m_abort pulse is seen afterwards.

Source files
------------

// File: rtl/i2c_cmd_arbiter_if.sv
// ---------------------------------------------------------------------------
// i2c_cmd_arbiter_if
// Bundles every handshake/bus signal of the I2C command arbiter.
//   requester side : reqN_valid/ready/rw/dev/reg/wdata, rspN_valid,
//                    rsp_rdata, rsp_err
//   master side    : m_start, m_abort, m_rw/dev/reg/wdata, m_done,
//                    m_nack, m_rdata
//   status         : busy
// Modports:
//   slave  - the arbiter's view (drives ready/rsp/m_* outputs)
//   master - the environment's view (requesters plus I2C master engine)
// ---------------------------------------------------------------------------
interface i2c_cmd_arbiter_if;
    logic       req0_valid;
    logic       req1_valid;
    logic       req0_ready;
    logic       req1_ready;
    logic       req0_rw;
    logic       req1_rw;
    logic [6:0] req0_dev;
    logic [6:0] req1_dev;
    logic [7:0] req0_reg;
    logic [7:0] req1_reg;
    logic [7:0] req0_wdata;
    logic [7:0] req1_wdata;
    logic       rsp0_valid;
    logic       rsp1_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic       m_start;
    logic       m_abort;
    logic       m_rw;
    logic [6:0] m_dev;
    logic [7:0] m_reg;
    logic [7:0] m_wdata;
    logic       m_done;
    logic       m_nack;
    logic [7:0] m_rdata;
    logic       busy;

    modport slave (
        input  req0_valid, req1_valid, req0_rw, req1_rw, req0_dev, req1_dev,
               req0_reg, req1_reg, req0_wdata, req1_wdata,
               m_done, m_nack, m_rdata,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata,
               rsp_err, m_start, m_abort, m_rw, m_dev, m_reg, m_wdata, busy
    );

    modport master (
        output req0_valid, req1_valid, req0_rw, req1_rw, req0_dev, req1_dev,
               req0_reg, req1_reg, req0_wdata, req1_wdata,
               m_done, m_nack, m_rdata,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata,
               rsp_err, m_start, m_abort, m_rw, m_dev, m_reg, m_wdata, busy
    );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_cmd_arbiter
// Round-robin arbiter between two I2C command requesters in front of a
// single I2C master engine. Handles NACK retries and a WAIT timeout.
// Ports:
//   clk  - system clock
//   rst  - synchronous reset, active-low
//   bus  - i2c_cmd_arbiter_if.slave (requester, response and master signals)
// Parameters:
//   TIMEOUT_CYC - WAIT cycles before abort (1..1023)
//   MAX_RETRY   - re-issues allowed after NACK (0..3)
//
// state | meaning
// IDLE  | no command held; ready offered to the granted requester
// ISSUE | one-cycle m_start pulse, timer cleared
// WAIT  | waiting for m_done; timer counts, NACK retry or timeout
// RESP  | one-cycle rsp pulse to the owner, last_grant updated
// ---------------------------------------------------------------------------
module i2c_cmd_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 1023,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic               clk,
    input  logic               rst,
    i2c_cmd_arbiter_if.slave   bus
);
    localparam logic [9:0] TMO  = 10'(TIMEOUT_CYC);
    localparam logic [1:0] MAXR = 2'(MAX_RETRY);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_last_grant;
    logic       r_owner;
    logic       r_rw;
    logic [6:0] r_dev;
    logic [7:0] r_reg;
    logic [7:0] r_wdata;
    logic [1:0] r_retry_cnt;
    logic [9:0] r_timer;
    logic [7:0] r_rsp_rdata;
    logic [1:0] r_rsp_err;

    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_xfer;
    logic       w_start;
    logic       w_abort;
    logic       w_rsp;
    logic       w_retry;
    logic       w_ld_rsp;
    logic [7:0] w_rsp_rdata;
    logic [1:0] w_rsp_err;

    // On a tie the requester that was not served last wins; the two grants
    // are mutually exclusive by construction.
    assign w_gnt0 = bus.req0_valid & (~bus.req1_valid | r_last_grant);
    assign w_gnt1 = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);

    always_comb begin
        w_next      = r_state;
        w_xfer      = 1'b0;
        w_start     = 1'b0;
        w_abort     = 1'b0;
        w_rsp       = 1'b0;
        w_retry     = 1'b0;
        w_ld_rsp    = 1'b0;
        w_rsp_rdata = 8'h00;
        w_rsp_err   = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (w_gnt0 | w_gnt1) begin
                    w_xfer = 1'b1;
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_start = 1'b1;
                w_next  = S_WAIT;
            end
            S_WAIT: begin
                // m_done has priority over a timeout in the same cycle
                if (bus.m_done) begin
                    if (!bus.m_nack) begin
                        w_ld_rsp    = 1'b1;
                        w_rsp_rdata = r_rw ? bus.m_rdata : 8'h00;
                        w_next      = S_RESP;
                    end else if (r_retry_cnt < MAXR) begin
                        w_retry = 1'b1;
                        w_next  = S_ISSUE;
                    end else begin
                        w_ld_rsp  = 1'b1;
                        w_rsp_err = 2'b01;
                        w_next    = S_RESP;
                    end
                end else if (r_timer == TMO) begin
                    w_abort   = 1'b1;
                    w_ld_rsp  = 1'b1;
                    w_rsp_err = 2'b10;
                    w_next    = S_RESP;
                end
            end
            S_RESP: begin
                w_rsp  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_rw         <= 1'b0;
            r_dev        <= 7'h00;
            r_reg        <= 8'h00;
            r_wdata      <= 8'h00;
            r_retry_cnt  <= 2'd0;
            r_timer      <= 10'd0;
            r_rsp_rdata  <= 8'h00;
            r_rsp_err    <= 2'b00;
        end else begin
            r_state <= w_next;
            if (w_xfer) begin
                r_owner     <= w_gnt1;
                r_rw        <= w_gnt1 ? bus.req1_rw    : bus.req0_rw;
                r_dev       <= w_gnt1 ? bus.req1_dev   : bus.req0_dev;
                r_reg       <= w_gnt1 ? bus.req1_reg   : bus.req0_reg;
                r_wdata     <= w_gnt1 ? bus.req1_wdata : bus.req0_wdata;
                r_retry_cnt <= 2'd0;
            end else if (w_retry) begin
                r_retry_cnt <= r_retry_cnt + 2'd1;
            end
            if (r_state == S_ISSUE) begin
                r_timer <= 10'd0;
            end else if (r_state == S_WAIT && !bus.m_done) begin
                r_timer <= r_timer + 10'd1;
            end
            if (w_ld_rsp) begin
                r_rsp_rdata <= w_rsp_rdata;
                r_rsp_err   <= w_rsp_err;
            end
            if (r_state == S_RESP) begin
                r_last_grant <= r_owner;
            end
        end
    end

    // Every output is gated with rst so the block is silent during the whole
    // reset cycle, including the one before the reset edge takes effect.
    assign bus.req0_ready = rst & (r_state == S_IDLE) & w_gnt0;
    assign bus.req1_ready = rst & (r_state == S_IDLE) & w_gnt1;
    assign bus.rsp0_valid = rst & w_rsp & ~r_owner;
    assign bus.rsp1_valid = rst & w_rsp & r_owner;
    assign bus.rsp_rdata  = {8{rst}} & r_rsp_rdata;
    assign bus.rsp_err    = {2{rst}} & r_rsp_err;
    assign bus.m_start    = rst & w_start;
    assign bus.m_abort    = rst & w_abort;
    assign bus.m_rw       = rst & r_rw;
    assign bus.m_dev      = {7{rst}} & r_dev;
    assign bus.m_reg      = {8{rst}} & r_reg;
    assign bus.m_wdata    = {8{rst}} & r_wdata;
    assign bus.busy       = rst & (r_state != S_IDLE);
endmodule
